// File: rtl/pipe_ctrl_pkg.sv
// Shared core package: pipeline sequencer state encoding, per-stage
// control bundle and the stage indices used to address it.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2,
    HALT     = 2'd3
  } pipe_state_t;

  // One stage register's control: advance (en) and/or load a bubble (flush).
  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam int NUM_STAGES = 5;
  localparam int ST_PC      = 0;
  localparam int ST_IFID    = 1;
  localparam int ST_IDEX    = 2;
  localparam int ST_EXMEM   = 3;
  localparam int ST_MEMWB   = 4;

  function automatic stage_ctrl_t stage_ctrl(input logic en, input logic flush);
    stage_ctrl_t c;
    c.en    = en;
    c.flush = flush;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline sequencer bus: stall/flush requests from the hazard unit and
// the EX/MEM/WB stages, and the per-stage enables/flushes, status and
// stall counter driven back to the core.
//   master : the sequencer (consumes requests, drives controls)
//   slave  : the pipeline side (drives requests, consumes controls)
interface pipe_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int CNT_W = 32
);
  // requests
  logic             load_use_ID;
  logic             redirect_EX;
  logic             mdu_start_EX;
  logic             mdu_done;
  logic             dmem_req_MEM;
  logic             dmem_ready;
  logic             halt_WB;
  // controls
  logic             pc_en;
  logic             IFID_en;
  logic             IDEX_en;
  logic             EXMEM_en;
  logic             MEMWB_en;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             EXMEM_flush;
  logic             MEMWB_flush;
  logic             halted;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  load_use_ID, redirect_EX, mdu_start_EX, mdu_done,
           dmem_req_MEM, dmem_ready, halt_WB,
    output pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
           IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush,
           halted, bus_err, stall_cycles
  );

  modport slave (
    output load_use_ID, redirect_EX, mdu_start_EX, mdu_done,
           dmem_req_MEM, dmem_ready, halt_WB,
    input  pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
           IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush,
           halted, bus_err, stall_cycles
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk : clock
//   clr : synchronous clear (wins over inc)
//   inc : count one when set; holds at all-ones
//   q   : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage RV32 core. Resolves stall and
// flush requests by priority (halt > mem stall > MDU stall > redirect >
// load-use) into per-stage enables/flushes, tracks multi-cycle waits with
// a small FSM, times out stuck data-memory accesses and counts stall cycles.
//   clk   : core clock
//   rst_n : synchronous reset, active-low
//   bus   : request inputs / stage controls, status and stall counter
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.master bus
);

  localparam int TCNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

  pipe_state_t state, state_nxt;
  logic        mdu_pend, mdu_pend_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic        bus_err_q, bus_err_nxt;

  stage_ctrl_t [NUM_STAGES-1:0] ctrl;
  logic        halted_c;

  logic        mem_stall;
  logic        mdu_wait_l;
  logic        run_l;
  logic        mdu_stall;

  // A mem stall during an MDU wait parks the FSM in MEM_WAIT with mdu_pend
  // set; logically the MDU op is still outstanding. Without mdu_pend,
  // MEM_WAIT behaves like RUN once memory releases, so a deferred redirect
  // or MDU start held in EX is acted on in the release cycle.
  assign mem_stall  = (state != HALT) && bus.dmem_req_MEM && !bus.dmem_ready;
  assign mdu_wait_l = (state == MDU_WAIT) || ((state == MEM_WAIT) && mdu_pend);
  assign run_l      = (state == RUN)      || ((state == MEM_WAIT) && !mdu_pend);
  assign mdu_stall  = (run_l && bus.mdu_start_EX) || (mdu_wait_l && !bus.mdu_done);

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      ctrl[i] = stage_ctrl(1'b1, 1'b0);
    end
    halted_c = 1'b0;

    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        ctrl[i] = stage_ctrl(1'b0, 1'b1);
      end
    end else if (state == HALT) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        ctrl[i] = stage_ctrl(1'b0, 1'b0);
      end
      halted_c = 1'b1;
    end else if (bus.halt_WB) begin
      // Freeze everything while the halting instruction retires.
      for (int i = 0; i < NUM_STAGES; i++) begin
        ctrl[i] = stage_ctrl(1'b0, 1'b0);
      end
    end else if (mem_stall) begin
      ctrl[ST_PC]    = stage_ctrl(1'b0, 1'b0);
      ctrl[ST_IFID]  = stage_ctrl(1'b0, 1'b0);
      ctrl[ST_IDEX]  = stage_ctrl(1'b0, 1'b0);
      ctrl[ST_EXMEM] = stage_ctrl(1'b0, 1'b0);
      ctrl[ST_MEMWB] = stage_ctrl(1'b1, 1'b1);
    end else if (mdu_stall) begin
      ctrl[ST_PC]    = stage_ctrl(1'b0, 1'b0);
      ctrl[ST_IFID]  = stage_ctrl(1'b0, 1'b0);
      ctrl[ST_IDEX]  = stage_ctrl(1'b0, 1'b0);
      ctrl[ST_EXMEM] = stage_ctrl(1'b1, 1'b1);
    end else if (run_l && bus.redirect_EX) begin
      // Wrong-path ID instruction is squashed, so any load-use is moot.
      ctrl[ST_IFID]  = stage_ctrl(1'b1, 1'b1);
      ctrl[ST_IDEX]  = stage_ctrl(1'b1, 1'b1);
    end else if (run_l && bus.load_use_ID) begin
      ctrl[ST_PC]    = stage_ctrl(1'b0, 1'b0);
      ctrl[ST_IFID]  = stage_ctrl(1'b0, 1'b0);
      ctrl[ST_IDEX]  = stage_ctrl(1'b1, 1'b1);
    end
  end

  always_comb begin
    state_nxt    = state;
    mdu_pend_nxt = 1'b0;
    tcnt_nxt     = mem_stall ? (tcnt + TCNT_W'(1)) : '0;
    bus_err_nxt  = mem_stall && (tcnt == TCNT_LAST);

    if (state == HALT) begin
      state_nxt = HALT;
    end else if (bus.halt_WB || bus_err_nxt) begin
      state_nxt = HALT;
    end else if (mem_stall) begin
      state_nxt    = MEM_WAIT;
      mdu_pend_nxt = mdu_wait_l;
    end else if (mdu_wait_l) begin
      state_nxt = bus.mdu_done ? RUN : MDU_WAIT;
    end else if (bus.mdu_start_EX) begin
      state_nxt = MDU_WAIT;
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      mdu_pend  <= 1'b0;
      tcnt      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      mdu_pend  <= mdu_pend_nxt;
      tcnt      <= tcnt_nxt;
      bus_err_q <= bus_err_nxt;
    end
  end

  // The PC register has no bubble to load; a flush request just holds it.
  assign bus.pc_en       = ctrl[ST_PC].en & ~ctrl[ST_PC].flush;
  assign bus.IFID_en     = ctrl[ST_IFID].en;
  assign bus.IDEX_en     = ctrl[ST_IDEX].en;
  assign bus.EXMEM_en    = ctrl[ST_EXMEM].en;
  assign bus.MEMWB_en    = ctrl[ST_MEMWB].en;
  assign bus.IFID_flush  = ctrl[ST_IFID].flush;
  assign bus.IDEX_flush  = ctrl[ST_IDEX].flush;
  assign bus.EXMEM_flush = ctrl[ST_EXMEM].flush;
  assign bus.MEMWB_flush = ctrl[ST_MEMWB].flush;
  assign bus.halted      = halted_c;
  assign bus.bus_err     = bus_err_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (!rst_n),
    .inc (rst_n && !bus.pc_en && (state != HALT)),
    .q   (bus.stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus();

  pipe_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ctl = {pc,IFID,IDEX,EXMEM,MEMWB en, IFID,IDEX,EXMEM,MEMWB flush, halted, bus_err}
  typedef struct {
    logic [10:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: what the pipeline is doing, not how the RTL encodes it.
  bit m_halted   = 1'b0;
  bit m_mdu_busy = 1'b0;
  bit m_bus_err  = 1'b0;
  int m_mem_cnt  = 0;
  int m_stall    = 0;

  task automatic step(input bit r, input bit lu, input bit rd, input bit ms,
                      input bit md, input bit req, input bit rdy, input bit hw);
    bit [4:0] en;
    bit [3:0] fl;
    bit       mem_blk;
    exp_t     e;
    rst_n            = r;
    bus.load_use_ID  = lu;
    bus.redirect_EX  = rd;
    bus.mdu_start_EX = ms;
    bus.mdu_done     = md;
    bus.dmem_req_MEM = req;
    bus.dmem_ready   = rdy;
    bus.halt_WB      = hw;

    mem_blk = req && !rdy;
    en = 5'b11111;
    fl = 4'b0000;
    if (!r) begin
      en = 5'b00000; fl = 4'b1111;
    end else if (m_halted || hw) begin
      en = 5'b00000; fl = 4'b0000;
    end else if (mem_blk) begin
      en = 5'b00001; fl = 4'b0001;
    end else if ((m_mdu_busy && !md) || (!m_mdu_busy && ms)) begin
      en = 5'b00011; fl = 4'b0010;
    end else if (m_mdu_busy) begin
      en = 5'b11111;
    end else if (rd) begin
      fl = 4'b1100;
    end else if (lu) begin
      en = 5'b00111; fl = 4'b0100;
    end
    e.ctl = {en, fl, (r && m_halted), m_bus_err};
    e.cnt = CNT_W'(m_stall);
    sb.push_back(e);

    if (!r) begin
      m_halted = 0; m_mdu_busy = 0; m_bus_err = 0; m_mem_cnt = 0; m_stall = 0;
    end else if (m_halted) begin
      m_bus_err = 0;
    end else begin
      m_bus_err = mem_blk && (m_mem_cnt == MEM_TIMEOUT - 1);
      m_mem_cnt = mem_blk ? m_mem_cnt + 1 : 0;
      if (!en[4] && m_stall < CNT_MAX) m_stall++;
      if (hw || m_bus_err) m_halted = 1;
      else if (!mem_blk) m_mdu_busy = m_mdu_busy ? !md : ms;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [10:0] a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {bus.pc_en, bus.IFID_en, bus.IDEX_en, bus.EXMEM_en, bus.MEMWB_en,
           bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_flush, bus.MEMWB_flush,
           bus.halted, bus.bus_err};
      n_tests++;
      if (a !== e.ctl) begin
        n_fail++;
        $display("FAIL ctl @%0t: got %b want %b", $time, a, e.ctl);
      end
      n_tests++;
      if (bus.stall_cycles !== e.cnt) begin
        n_fail++;
        $display("FAIL stall_cycles @%0t: got %0d want %0d", $time, bus.stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    bit r, lu, rd, ms, md, req, rdy, hw, burst;
    bus.load_use_ID  = 0;
    bus.redirect_EX  = 0;
    bus.mdu_start_EX = 0;
    bus.mdu_done     = 0;
    bus.dmem_req_MEM = 0;
    bus.dmem_ready   = 0;
    bus.halt_WB      = 0;
    burst = 0;
    @(posedge clk);
    #1;

    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 0, 1);
    idle(2);
    // single load-use
    step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // redirect with load-use in the same cycle
    step(1, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    // three-cycle memory wait, released on the fourth
    repeat (3) step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    idle(1);
    // redirect deferred by a mem stall, applied on release
    step(1, 0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0, 1, 1, 0);
    idle(1);
    // MDU op with a two-cycle mem stall mid-wait
    step(1, 0, 0, 1, 0, 0, 0, 0);
    idle(2);
    repeat (2) step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    // memory timeout -> bus_err pulse, then halted until reset
    repeat (MEM_TIMEOUT) step(1, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) step(1, 1, 1, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // halt during an MDU wait, then reset
    step(1, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 40 == 0) burst = !burst;
      r   = !((m_halted && ($urandom % 4 == 0)) || ($urandom % 300 == 0));
      lu  = ($urandom % 4 == 0);
      rd  = ($urandom % 5 == 0);
      ms  = ($urandom % 8 == 0);
      md  = ($urandom % 4 == 0);
      req = burst ? 1'b1 : ($urandom % 3 == 0);
      rdy = burst ? ($urandom % 24 == 0) : ($urandom % 2 == 0);
      hw  = ($urandom % 150 == 0);
      step(r, lu, rd, ms, md, req, rdy, hw);
    end
    idle(2);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32 core. It takes stall and flush requests from the hazard unit (load-use), EX (branch/jump redirect, multi-cycle MDU op), MEM (data-memory wait states) and WB (halt), and resolves them by priority. It drives per-stage register enables and flushes, and tracks multi-cycle waits with a small FSM, a memory-timeout counter and a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before a bus error.
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous reset, active-low
load_use_ID  in  1  load-use hazard from the hazard unit
redirect_EX  in  1  taken branch/jump resolved in EX
mdu_start_EX  in  1  multi-cycle mul/div op entering EX
mdu_done  in  1  MDU result valid
dmem_req_MEM  in  1  load/store active in MEM
dmem_ready  in  1  data memory completes the access this cycle
halt_WB  in  1  ecall/ebreak retiring in WB
pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1 each  stage register enables
IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush  out  1 each  load a bubble into that stage register
halted  out  1  core stopped
bus_err  out  1  one-cycle pulse on memory timeout
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 while not HALT

Behaviour:
- Clock and reset: clk; rst_n is synchronous and active-low.
- FSM states: RUN, MEM_WAIT, MDU_WAIT, HALT.
- Reset values: state=RUN, timeout counter=0, stall_cycles=0, bus_err=0.
- While rst_n=0: all enables=0, all flushes=1, halted=0.
- Enables and flushes are combinational from state and inputs. Default in RUN: all enables=1, all flushes=0.
- Priority, highest first: halt > mem stall > MDU stall > redirect > load-use.
- halt_WB (any state except reset): next state=HALT.
  - In HALT: all enables=0, flushes=0, halted=1.
  - HALT is left only by reset.
- Mem stall (dmem_req_MEM=1 and dmem_ready=0, in RUN or MEM_WAIT):
  - pc/IFID/IDEX/EXMEM_en=0; MEMWB_flush=1.
  - State becomes MEM_WAIT and the timeout counter increments.
  - When dmem_ready=1: release in that same cycle (RUN defaults apply), clear the counter, return to RUN.
- Timeout: counter reaches MEM_TIMEOUT-1 with still no ready → next cycle bus_err=1 for one cycle, state=HALT.
- MDU stall (mdu_start_EX in RUN, or MDU_WAIT with mdu_done=0):
  - pc/IFID/IDEX_en=0; EXMEM_flush=1.
  - State becomes MDU_WAIT.
  - The cycle mdu_done=1: release (IDEX/EXMEM advance), return to RUN.
  - A mem stall arising during MDU_WAIT overrides the outputs. The FSM remains logically in MDU_WAIT; track this with a sticky flag. After memory releases, resume MDU_WAIT.
- Redirect (RUN only, no higher source): pc_en=1, IFID_flush=1, IDEX_flush=1.
  - load_use_ID in the same cycle is ignored, because that instruction is wrong-path.
  - Redirect during a mem stall is deferred. EX is held, so redirect_EX stays high and is applied on release.
- Load-use (RUN only, no higher source): pc_en=0, IFID_en=0, IDEX_flush=1; other enables=1. Lasts one cycle with no state change.
- mdu_done asserted in RUN: ignored.
- stall_cycles: increments when pc_en=0, state≠HALT and rst_n=1. Saturates at all-ones.

Decomposition:
- Shared package (existing core pkg):
  - typedef enum logic [1:0] pipe_state_t {RUN, MEM_WAIT, MDU_WAIT, HALT}
  - struct stage_ctrl_t {en, flush} used for all five stages
- Sub-module sat_counter (parameter W, inc, clr, saturating). Instantiated for stall_cycles. The timeout counter is a plain local counter.

Test Plan:
- load_use_ID=1 for one cycle in RUN → pc_en=0, IFID_en=0, IDEX_flush=1 for exactly 1 cycle; stall_cycles=1.
- redirect_EX=1 and load_use_ID=1 together → pc_en=1, IFID_flush=IDEX_flush=1; stall_cycles unchanged.
- dmem_req_MEM=1, dmem_ready=0 for 3 cycles, then 1 → MEMWB_flush=1 and EXMEM_en=0 for 3 cycles, release on the 4th; stall_cycles=3.
- mdu_start_EX, mdu_done after 5 cycles, with a 2-cycle mem stall inserted mid-wait → EXMEM_flush during MDU cycles, MEMWB_flush during mem cycles, MDU_WAIT resumed, release on mdu_done.
- dmem_ready held 0 for 16 cycles (MEM_TIMEOUT=16) → single-cycle bus_err, then halted=1 and all enables=0 until rst_n=0.
- halt_WB during MDU_WAIT → HALT next cycle; then rst_n=0 for 1 cycle → RUN, stall_cycles=0.
